// File: rtl/mio_pkg.sv
// Shared types and address map for the MIO bus responder.
package mio_pkg;

  localparam int RAM_IDX_W = 10;

  localparam logic [3:0]  RAM_REGION = 4'h0;
  localparam logic [31:0] GPIO_ADDR  = 32'hF000_0000;
  localparam logic [31:0] CNT_ADDR   = 32'hF000_0004;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    RELEASE
  } mio_state_e;

  function automatic logic [RAM_IDX_W-1:0] ram_index(input logic [31:0] addr);
    return addr[RAM_IDX_W+1:2];
  endfunction

endpackage

// File: rtl/mio_addr_decode.sv
// One-hot address decoder for the MIO bus responder.
// The COUNTER slot only decodes when MIO_COUNTER_EN is defined.
module mio_addr_decode
  import mio_pkg::*;
(
  input  logic [31:0] addr,
  output logic        is_ram,
  output logic        is_gpio,
  output logic        is_cnt,
  output logic        is_unmapped
);

  always_comb begin
    is_ram  = (addr[31:28] == RAM_REGION);
    is_gpio = (addr == GPIO_ADDR);
`ifdef MIO_COUNTER_EN
    is_cnt  = (addr == CNT_ADDR);
`else
    is_cnt  = 1'b0;
`endif
    is_unmapped = !(is_ram || is_gpio || is_cnt);
  end

endmodule

// File: rtl/mio_bus_responder.sv
// CPU memory/IO bus responder: word RAM with configurable wait states, GPIO, and
// an optional free-running COUNTER register enabled by the MIO_COUNTER_EN macro.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int RAM_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 CPU_MIO,
  input  logic                 mem_w,
  input  logic [31:0]          addr_bus,
  input  logic [31:0]          Data_out,
  output logic [31:0]          Data_in,
  output logic                 MIO_ready,
  output logic [RAM_IDX_W-1:0] ram_addr,
  output logic [31:0]          ram_din,
  output logic                 ram_we,
  input  logic [31:0]          ram_dout,
  input  logic [15:0]          sw_in,
  output logic [7:0]           led_out
);

  localparam logic [3:0] WAIT_LAST = 4'(RAM_WAIT - 1);

  mio_state_e           state_q, state_d;
  logic [3:0]           wait_q, wait_d;
  logic [RAM_IDX_W-1:0] idx_q, idx_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 wr_q, wr_d;
  logic [31:0]          data_in_q, data_in_d;
  logic                 ready_q, ready_d;
  logic                 ram_we_q, ram_we_d;
  logic [7:0]           led_q, led_d;
  logic [31:0]          cnt_rd;

  logic is_ram, is_gpio, is_cnt, is_unmapped;

  mio_addr_decode u_decode (
    .addr        (addr_bus),
    .is_ram      (is_ram),
    .is_gpio     (is_gpio),
    .is_cnt      (is_cnt),
    .is_unmapped (is_unmapped)
  );

`ifdef MIO_COUNTER_EN
  logic [31:0] cnt_q, cnt_d;
  assign cnt_rd = cnt_q;
`else
  assign cnt_rd = '0;
`endif

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    wr_d      = wr_q;
    data_in_d = data_in_q;
    ready_d   = 1'b0;
    ram_we_d  = 1'b0;
    led_d     = led_q;
`ifdef MIO_COUNTER_EN
    cnt_d     = cnt_q + 32'd1;
`endif

    unique case (state_q)
      IDLE: begin
        if (CPU_MIO) begin
          idx_d   = ram_index(addr_bus);
          wdata_d = Data_out;
          wr_d    = mem_w;
          if (is_ram) begin
            state_d  = ACCESS;
            wait_d   = 4'd0;
            ram_we_d = mem_w;
          end else begin
            // Peripherals complete immediately; their side effects land on the request edge.
            state_d = RESP;
            ready_d = 1'b1;
            if (mem_w) begin
              if (is_gpio) led_d = Data_out[7:0];
`ifdef MIO_COUNTER_EN
              if (is_cnt) cnt_d = Data_out;
`endif
            end else if (is_unmapped) begin
              data_in_d = '0;
            end else if (is_gpio) begin
              data_in_d = {16'h0, sw_in};
            end else begin
              data_in_d = cnt_rd;
            end
          end
        end
      end
      ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          state_d = RESP;
          ready_d = 1'b1;
          wait_d  = 4'd0;
          if (!wr_q) data_in_d = ram_dout;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      RESP: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        // Wait for the strobe to drop so a held request is never replayed.
        if (!CPU_MIO) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wait_q    <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      data_in_q <= '0;
      ready_q   <= 1'b0;
      ram_we_q  <= 1'b0;
      led_q     <= '0;
`ifdef MIO_COUNTER_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      wr_q      <= wr_d;
      data_in_q <= data_in_d;
      ready_q   <= ready_d;
      ram_we_q  <= ram_we_d;
      led_q     <= led_d;
`ifdef MIO_COUNTER_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign Data_in   = data_in_q;
  assign MIO_ready = ready_q;
  assign ram_addr  = idx_q;
  assign ram_din   = wdata_q;
  assign ram_we    = ram_we_q;
  assign led_out   = led_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: two instances (RAM_WAIT=1 and 3) against a
// transaction-level model of expected completion cycles and register contents.
module tb_mio_bus_responder;

  localparam int W0 = 1;
  localparam int W1 = 3;
`ifdef MIO_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_mio  [2];
  logic        mem_w    [2];
  logic [31:0] addr_bus [2];
  logic [31:0] data_out [2];
  logic [31:0] data_in  [2];
  logic        mio_ready[2];
  logic [9:0]  ram_addr [2];
  logic [31:0] ram_din  [2];
  logic        ram_we   [2];
  logic [31:0] ram_dout [2];
  logic [7:0]  led_out  [2];
  logic [15:0] sw_in;

  logic [31:0] env_mem0 [1024];
  logic [31:0] env_mem1 [1024];

  always #5 clk = ~clk;

  mio_bus_responder #(.RAM_WAIT(W0)) dut0 (
    .clk(clk), .rst(rst), .CPU_MIO(cpu_mio[0]), .mem_w(mem_w[0]),
    .addr_bus(addr_bus[0]), .Data_out(data_out[0]), .Data_in(data_in[0]),
    .MIO_ready(mio_ready[0]), .ram_addr(ram_addr[0]), .ram_din(ram_din[0]),
    .ram_we(ram_we[0]), .ram_dout(ram_dout[0]), .sw_in(sw_in), .led_out(led_out[0])
  );

  mio_bus_responder #(.RAM_WAIT(W1)) dut1 (
    .clk(clk), .rst(rst), .CPU_MIO(cpu_mio[1]), .mem_w(mem_w[1]),
    .addr_bus(addr_bus[1]), .Data_out(data_out[1]), .Data_in(data_in[1]),
    .MIO_ready(mio_ready[1]), .ram_addr(ram_addr[1]), .ram_din(ram_din[1]),
    .ram_we(ram_we[1]), .ram_dout(ram_dout[1]), .sw_in(sw_in), .led_out(led_out[1])
  );

  // Async-read word RAMs behind each instance.
  assign ram_dout[0] = env_mem0[ram_addr[0]];
  assign ram_dout[1] = env_mem1[ram_addr[1]];
  always @(posedge clk) begin
    if (ram_we[0] === 1'b1) env_mem0[ram_addr[0]] = ram_din[0];
    if (ram_we[1] === 1'b1) env_mem1[ram_addr[1]] = ram_din[1];
  end

  // Reference model: cycle-stamped expectations per instance.
  int          cyc = 0;
  int          ready_cyc[2], we_cyc[2], din_upd[2], led_upd[2];
  int          acc_lo[2], acc_hi[2], cnt_base_cyc[2];
  logic [31:0] din_new[2], exp_din[2], we_data[2], cnt_base[2];
  logic [9:0]  acc_idx[2];
  logic [7:0]  led_new[2], exp_led[2];
  logic [31:0] ref_mem[2][1024];
  int          ready_seen[2], we_seen[2];
  int          total = 0;
  int          bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic predictRequest(input int i, input int n, input logic [31:0] a,
                                input logic w, input logic [31:0] d);
    int wt;
    logic [9:0] idx;
    wt  = (i == 0) ? W0 : W1;
    idx = a[11:2];
    if (a[31:28] == 4'h0) begin
      ready_cyc[i] = n + wt;
      acc_lo[i] = n;
      acc_hi[i] = n + wt - 1;
      acc_idx[i] = idx;
      if (w) begin
        we_cyc[i] = n;
        we_data[i] = d;
        ref_mem[i][idx] = d;
      end else begin
        din_upd[i] = n + wt;
        din_new[i] = ref_mem[i][idx];
      end
    end else begin
      ready_cyc[i] = n;
      if (a == 32'hF000_0000) begin
        if (w) begin
          led_upd[i] = n;
          led_new[i] = d[7:0];
        end else begin
          din_upd[i] = n;
          din_new[i] = {16'h0, sw_in};
        end
      end else if (CNT_EN && a == 32'hF000_0004) begin
        if (w) begin
          cnt_base[i] = d;
          cnt_base_cyc[i] = n;
        end else begin
          din_upd[i] = n;
          din_new[i] = cnt_base[i] + 32'(n - 1 - cnt_base_cyc[i]);
        end
      end else if (!w) begin
        din_upd[i] = n;
        din_new[i] = '0;
      end
    end
  endtask

  // Issue one request, hold the strobe `hold` cycles past MIO_ready, then idle.
  task automatic applyStimulus(input int i, input logic [31:0] a, input logic w,
                               input logic [31:0] d, input int hold, input int gap,
                               output int lat);
    int n;
    int waited;
    addr_bus[i] = a;
    mem_w[i] = w;
    data_out[i] = d;
    cpu_mio[i] = 1'b1;
    n = cyc + 1;
    predictRequest(i, n, a, w, d);
    lat = -1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (mio_ready[i] !== 1'b1 && waited < 40);
    if (mio_ready[i] === 1'b1) begin
      lat = cyc + 1 - n;
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL ready_timeout%0d: got no MIO_ready, required one within 40 cycles", i);
    end
    repeat (hold) @(negedge clk);
    cpu_mio[i] = 1'b0;
    repeat (2 + gap) @(negedge clk);
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        exp_din[i] = '0;
        exp_led[i] = '0;
        ready_cyc[i] = -1;
        we_cyc[i] = -1;
        din_upd[i] = -1;
        led_upd[i] = -1;
        acc_lo[i] = -1;
        acc_hi[i] = -2;
        cnt_base[i] = '0;
        cnt_base_cyc[i] = cyc;
      end
    end
  end

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < 2; i++) begin
        if (cyc == din_upd[i]) exp_din[i] = din_new[i];
        if (cyc == led_upd[i]) exp_led[i] = led_new[i];
        if (mio_ready[i] === 1'b1) ready_seen[i]++;
        if (ram_we[i] === 1'b1) we_seen[i]++;
        checkOutput($sformatf("mio_ready%0d", i), 32'(mio_ready[i]), 32'(cyc == ready_cyc[i]));
        checkOutput($sformatf("ram_we%0d", i), 32'(ram_we[i]), 32'(cyc == we_cyc[i]));
        checkOutput($sformatf("data_in%0d", i), data_in[i], exp_din[i]);
        checkOutput($sformatf("led_out%0d", i), 32'(led_out[i]), 32'(exp_led[i]));
        if (cyc >= acc_lo[i] && cyc <= acc_hi[i])
          checkOutput($sformatf("ram_addr%0d", i), 32'(ram_addr[i]), 32'(acc_idx[i]));
        if (cyc == we_cyc[i])
          checkOutput($sformatf("ram_din%0d", i), ram_din[i], we_data[i]);
      end
    end
  end

  initial begin
    int lat;
    int ws;
    int rs;
    int n;
    for (int j = 0; j < 1024; j++) begin
      env_mem0[j] = '0;
      env_mem1[j] = '0;
      ref_mem[0][j] = '0;
      ref_mem[1][j] = '0;
    end
    for (int i = 0; i < 2; i++) begin
      cpu_mio[i] = 1'b0;
      mem_w[i] = 1'b0;
      addr_bus[i] = '0;
      data_out[i] = '0;
      ready_seen[i] = 0;
      we_seen[i] = 0;
    end
    sw_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // RAM_WAIT=1 write then read.
    ws = we_seen[0];
    applyStimulus(0, 32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 0, 0, lat);
    checkOutput("w1_write_we_pulses", 32'(we_seen[0] - ws), 32'd1);
    checkOutput("w1_write_latency", 32'(lat), 32'd2);
    applyStimulus(0, 32'h0000_0010, 1'b0, 32'h0, 0, 0, lat);
    checkOutput("w1_read_latency", 32'(lat), 32'd2);
    checkOutput("w1_read_data", data_in[0], 32'hDEAD_BEEF);

    // RAM_WAIT=3 read.
    applyStimulus(1, 32'h0000_0040, 1'b1, 32'h0BAD_F00D, 0, 0, lat);
    rs = ready_seen[1];
    applyStimulus(1, 32'h0000_0040, 1'b0, 32'h0, 0, 0, lat);
    checkOutput("w3_read_latency", 32'(lat), 32'd4);
    checkOutput("w3_read_ready_pulses", 32'(ready_seen[1] - rs), 32'd1);
    checkOutput("w3_read_data", data_in[1], 32'h0BAD_F00D);

    // GPIO write and read.
    sw_in = 16'h1234;
    applyStimulus(0, 32'hF000_0000, 1'b1, 32'h0000_00A5, 0, 0, lat);
    checkOutput("gpio_write_latency", 32'(lat), 32'd1);
    checkOutput("gpio_led", 32'(led_out[0]), 32'h0000_00A5);
    applyStimulus(0, 32'hF000_0000, 1'b0, 32'h0, 0, 0, lat);
    checkOutput("gpio_read_latency", 32'(lat), 32'd1);
    checkOutput("gpio_read_data", data_in[0], 32'h0000_1234);

    // Strobe held five cycles past completion.
    ws = we_seen[0];
    rs = ready_seen[0];
    applyStimulus(0, 32'h0000_0020, 1'b1, 32'hCAFE_F00D, 5, 0, lat);
    checkOutput("hold_ready_pulses", 32'(ready_seen[0] - rs), 32'd1);
    checkOutput("hold_we_pulses", 32'(we_seen[0] - ws), 32'd1);

    // Reset during the second ACCESS cycle of a RAM_WAIT=3 write.
    applyStimulus(1, 32'hF000_0000, 1'b1, 32'h0000_005A, 0, 0, lat);
    checkOutput("pre_rst_led", 32'(led_out[1]), 32'h0000_005A);
    ws = we_seen[1];
    rs = ready_seen[1];
    addr_bus[1] = 32'h0000_0080;
    mem_w[1] = 1'b1;
    data_out[1] = 32'h1357_9BDF;
    cpu_mio[1] = 1'b1;
    n = cyc + 1;
    predictRequest(1, n, 32'h0000_0080, 1'b1, 32'h1357_9BDF);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    cpu_mio[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("rst_we_pulses", 32'(we_seen[1] - ws), 32'd1);
    checkOutput("rst_ready_pulses", 32'(ready_seen[1] - rs), 32'd0);
    checkOutput("rst_led", 32'(led_out[1]), 32'd0);
    applyStimulus(1, 32'hF000_0000, 1'b0, 32'h0, 0, 0, lat);
    checkOutput("rst_then_idle_latency", 32'(lat), 32'd1);

    // COUNTER wrap: read issued four edges after the write edge.
    applyStimulus(0, 32'hF000_0004, 1'b1, 32'hFFFF_FFFE, 0, 1, lat);
    applyStimulus(0, 32'hF000_0004, 1'b0, 32'h0, 0, 0, lat);
    checkOutput("cnt_wrap_read", data_in[0], CNT_EN ? 32'h0000_0001 : 32'h0);

    // Randomized traffic over both instances.
    for (int k = 0; k < 250; k++) begin
      int i;
      int sel;
      int hold;
      int gap;
      logic [31:0] a;
      logic w;
      logic [31:0] d;
      i = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      sw_in = 16'($urandom);
      if (sel <= 4)      a = {4'h0, 16'($urandom), 10'($urandom_range(0, 31)), 2'($urandom)};
      else if (sel <= 6) a = 32'hF000_0000;
      else if (sel == 7) a = 32'hF000_0004;
      else if (sel == 8) a = 32'hF000_0008;
      else               a = {4'($urandom_range(1, 14)), 28'($urandom)};
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      hold = int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 2));
      applyStimulus(i, a, w, d, hold, gap, lat);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mio_bus_responder.md
MIO_BUS_RESPONDER -- requirements
Module: mio_bus_responder

Interface
REQ-001 The block SHALL have parameter RAM_WAIT, default 1, giving the number of ACCESS cycles for a RAM transfer (legal range 1..15).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 The block SHALL have port CPU_MIO, input, 1, CPU bus request strobe; held high until the CPU sees MIO_ready.
REQ-005 The block SHALL have port mem_w, input, 1, request is a write (1) or a read (0).
REQ-006 The block SHALL have port addr_bus, input, 32, CPU byte address.
REQ-007 The block SHALL have port Data_out, input, 32, CPU write data.
REQ-008 The block SHALL have port Data_in, output, 32, registered read data returned to the CPU.
REQ-009 The block SHALL have port MIO_ready, output, 1, one-cycle completion pulse.
REQ-010 The block SHALL have ports ram_addr output 10, ram_din output 32, ram_we output 1, and ram_dout input 32, forming the word-RAM port; ram_dout is async-read, valid within RAM_WAIT cycles.
REQ-011 The block SHALL have port sw_in, input, 16, switch inputs.
REQ-012 The block SHALL have port led_out, output, 8, registered LED outputs.

Function
REQ-013 The FSM SHALL have states IDLE, ACCESS, RESP and RELEASE.
REQ-014 In IDLE with CPU_MIO=1, the block SHALL latch addr_bus, Data_out and mem_w, then go to ACCESS for RAM addresses or to RESP for all other addresses.
REQ-015 Address decode SHALL be: addr[31:28]=0x0 is RAM (word index addr[11:2]); 0xF0000000 is GPIO; 0xF0000004 is COUNTER; everything else is unmapped.
REQ-016 ACCESS SHALL last exactly RAM_WAIT cycles, counted by a 4-bit wait counter.
REQ-017 ram_addr and ram_din SHALL be driven from the latched request throughout ACCESS.
REQ-018 ram_we SHALL be 1 only in the first ACCESS cycle of a write, and 0 at all other times.
REQ-019 On the last ACCESS cycle of a read, the block SHALL register ram_dout into Data_in.
REQ-020 MIO_ready SHALL be 1 for exactly the single RESP cycle.
REQ-021 Read latency SHALL be: request sampled at edge N gives MIO_ready at cycle N+1+RAM_WAIT for RAM and N+1 for peripherals.
REQ-022 A GPIO read SHALL return {16'h0, sw_in}, sampled on the request edge.
REQ-023 A GPIO write SHALL load led_out with Data_out[7:0] on the request edge.
REQ-024 An unmapped read SHALL return 32'h0, an unmapped write SHALL be discarded, and both SHALL still complete with MIO_ready.
REQ-025 Data_in SHALL hold its value until the next read completes; writes SHALL leave Data_in unchanged.
REQ-026 RESP SHALL always advance to RELEASE.
REQ-027 RELEASE SHALL go to IDLE once CPU_MIO=0 and SHALL otherwise remain in RELEASE, so one held strobe never executes twice.
REQ-028 Back-to-back requests SHALL be separated by at least one cycle with CPU_MIO=0.

Reset
REQ-029 While rst=1, the block SHALL set state=IDLE, the wait counter to 0, Data_in=0, MIO_ready=0, ram_we=0, led_out=0, and COUNTER=0.
REQ-030 If reset is asserted mid-operation in any state, the in-flight request SHALL be abandoned with no MIO_ready and no later ram_we; the CPU SHALL re-issue it.

Configuration
REQ-031 With MIO_COUNTER_EN defined, COUNTER SHALL be a 32-bit free-running register that increments every cycle and wraps 0xFFFFFFFF to 0.
REQ-032 With MIO_COUNTER_EN defined, a read of COUNTER SHALL return its value at the request edge.
REQ-033 With MIO_COUNTER_EN defined, a write to COUNTER SHALL load Data_out, and the write SHALL take priority over the increment in that cycle.
REQ-034 With MIO_COUNTER_EN undefined, no counter register SHALL exist and 0xF0000004 SHALL decode as unmapped.

Structure
REQ-035 Package mio_pkg SHALL hold the FSM state typedef, the RAM/GPIO/COUNTER base-address constants, and the RAM index width (10).
REQ-036 Sub-module mio_addr_decode SHALL be the combinational decoder: input addr 32; outputs is_ram, is_gpio, is_cnt, and is_unmapped, one-hot.

Verification
REQ-037 A bench SHALL check: RAM_WAIT=1, write 0xDEADBEEF to 0x00000010 then read it -> one ram_we pulse at ram_addr=4; read MIO_ready at N+2; Data_in=0xDEADBEEF.
REQ-038 A bench SHALL check: RAM_WAIT=3 read -> MIO_ready exactly at N+4 and only one cycle wide.
REQ-039 A bench SHALL check: write 0x000000A5 to 0xF0000000, sw_in=0x1234, then read 0xF0000000 -> led_out=0xA5, Data_in=0x00001234, each completing at N+1.
REQ-040 A bench SHALL check: CPU_MIO held high for 5 cycles after MIO_ready -> no second MIO_ready and no second ram_we until CPU_MIO drops.
REQ-041 A bench SHALL check: rst asserted in the second ACCESS cycle of a RAM_WAIT=3 write -> no MIO_ready and no further ram_we, state IDLE, led_out=0.
REQ-042 A bench SHALL check, with MIO_COUNTER_EN defined: write 0xFFFFFFFE to 0xF0000004, then read 3 cycles later -> wrapped value 0x00000001 (±fixed latency); with the macro undefined the same read returns 0.
